// File: rtl/avg_pool_pkg.sv
// Shared types and helpers for the average-pooling forward/backward blocks.
package avg_pool_pkg;

  typedef enum logic {StFill, StEmit} state_e;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned Log2K2 = 1;
  localparam int unsigned Log2K4 = 2;

  function automatic int unsigned log2_k(input int unsigned k);
    return (k == 4) ? Log2K4 : Log2K2;
  endfunction

  // Round-half-up divide by 2^s; 64-bit headroom covers DATA_W+1 for any DATA_W <= 63.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                     input int unsigned s);
    logic signed [63:0] half;
    half = 64'sd1 <<< (s - 1);
    return (x + half) >>> s;
  endfunction

endpackage

// File: rtl/avg_pool_2d_backward_if.sv
// Pooled-gradient input and full-resolution output streams, both valid/ready.
interface avg_pool_2d_backward_if
  import avg_pool_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic                     valid_in;
  logic                     ready_in;
  logic signed [DATA_W-1:0] input_data;
  logic                     valid_out;
  logic                     ready_out;
  logic signed [DATA_W-1:0] output_data;
  logic                     last_out;

  modport slave (
    input  valid_in, input_data, ready_out,
    output ready_in, valid_out, output_data, last_out
  );

  modport master (
    output valid_in, input_data, ready_out,
    input  ready_in, valid_out, output_data, last_out
  );

endinterface

// File: rtl/avg_pool_row_buffer.sv
// One pooled row of scaled samples: single write port, combinational read port.
module avg_pool_row_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/avg_pool_2d_backward.sv
// Average-pool backward pass: scale each pooled gradient by 1/(K*K) and
// broadcast it over its KxK window as a full-resolution raster stream.
module avg_pool_2d_backward
  import avg_pool_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned K      = 2,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned OUT_H  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  avg_pool_2d_backward_if.slave bus
);

  localparam int unsigned PW   = OUT_W / K;
  localparam int unsigned PH   = OUT_H / K;
  localparam int unsigned LogK = log2_k(K);
  localparam int unsigned S    = 2 * LogK;
  localparam int unsigned PwW  = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned PhW  = (PH > 1) ? $clog2(PH) : 1;
  localparam int unsigned ColW = $clog2(OUT_W);
  localparam int unsigned RepW = LogK;

  state_e                   state_q;
  logic [PwW-1:0]           col_in_q;
  logic [RepW-1:0]          rep_row_q;
  logic [ColW-1:0]          out_col_q;
  logic [PhW-1:0]           prow_q;
  logic                     valid_q;
  logic                     last_q;
  logic signed [DATA_W-1:0] data_q;

  logic                     accept;
  logic                     load;
  logic                     col_end;
  logic                     row_end;
  logic [PwW-1:0]           rd_addr;
  logic signed [DATA_W-1:0] scaled;
  logic signed [DATA_W-1:0] rd_data;

  always_comb begin
    accept  = (state_q == StFill) && bus.valid_in;
    load    = (state_q == StEmit) && (!valid_q || bus.ready_out);
    col_end = (out_col_q == ColW'(OUT_W - 1));
    row_end = col_end && (rep_row_q == RepW'(K - 1));
    rd_addr = PwW'(out_col_q >> LogK);
    scaled  = DATA_W'(round_shift(64'(signed'(bus.input_data)), S));
  end

  assign bus.ready_in    = (state_q == StFill);
  assign bus.valid_out   = valid_q;
  assign bus.output_data = data_q;
  assign bus.last_out    = last_q;

  avg_pool_row_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (PW),
    .ADDR_W(PwW)
  ) u_row_buffer (
    .clk  (clk),
    .we   (accept),
    .waddr(col_in_q),
    .wdata(scaled),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFill;
      col_in_q  <= '0;
      rep_row_q <= '0;
      out_col_q <= '0;
      prow_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (col_in_q == PwW'(PW - 1)) begin
              col_in_q <= '0;
              state_q  <= StEmit;
            end else begin
              col_in_q <= col_in_q + 1'b1;
            end
          end
        end
        StEmit: begin
          if (load && row_end) begin
            state_q <= StFill;
            prow_q  <= (prow_q == PhW'(PH - 1)) ? '0 : prow_q + 1'b1;
          end
        end
      endcase

      // Load takes priority so the register never bubbles while ready_out stays high.
      if (load) begin
        data_q    <= rd_data;
        valid_q   <= 1'b1;
        last_q    <= row_end && (prow_q == PhW'(PH - 1));
        out_col_q <= col_end ? '0 : out_col_q + 1'b1;
        if (col_end) begin
          rep_row_q <= rep_row_q + 1'b1;
        end
      end else if (valid_q && bus.ready_out) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_2d_backward.sv
// Self-checking bench: randomized pooled frames against a divide-and-broadcast model.
module tb_avg_pool_2d_backward;

  typedef logic signed [31:0] sample_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avg_pool_2d_backward_if #(.DATA_W(32)) b2 ();
  avg_pool_2d_backward_if #(.DATA_W(32)) b4 ();

  avg_pool_2d_backward #(.DATA_W(32), .K(2), .OUT_W(8), .OUT_H(8)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2)
  );

  avg_pool_2d_backward #(.DATA_W(32), .K(4), .OUT_W(8), .OUT_H(8)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b4)
  );

  sample_t got2_d[$];
  bit      got2_l[$];
  int      got2_t[$];
  sample_t got4_d[$];
  bit      got4_l[$];
  sample_t exp_d[$];
  bit      exp_l[$];

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && b2.valid_out && b2.ready_out) begin
      got2_d.push_back(b2.output_data);
      got2_l.push_back(b2.last_out);
      got2_t.push_back(cyc);
    end
    if (rst_n && b4.valid_out && b4.ready_out) begin
      got4_d.push_back(b4.output_data);
      got4_l.push_back(b4.last_out);
    end
  end

  // Nearest integer to x/(k*k), ties toward +inf.
  function automatic sample_t ref_scale(input longint x, input int k);
    longint kk;
    longint n;
    longint q;
    kk = longint'(k * k);
    n  = x + kk / 2;
    q  = n / kk;
    if ((n % kk) != 0 && n < 0) q = q - 1;
    return sample_t'(q);
  endfunction

  task automatic build_expected(input sample_t pooled[$], input int k, input int ow,
                                input int oh);
    int pw;
    int ph;
    int rows;
    pw   = ow / k;
    ph   = oh / k;
    rows = pooled.size() / pw;
    for (int r = 0; r < rows; r++)
      for (int rep = 0; rep < k; rep++)
        for (int x = 0; x < ow; x++) begin
          exp_d.push_back(ref_scale(longint'(pooled[r * pw + x / k]), k));
          exp_l.push_back((r % ph == ph - 1) && (rep == k - 1) && (x == ow - 1));
        end
  endtask

  task automatic clear_all();
    got2_d.delete(); got2_l.delete(); got2_t.delete();
    got4_d.delete(); got4_l.delete();
    exp_d.delete();  exp_l.delete();
  endtask

  task automatic send2(input sample_t v, input bit garbage, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b2.valid_in   = 1'b1;
    b2.input_data = v;
    while (b2.ready_in !== 1'b1) begin
      if (n >= 2000) begin
        ok = 1'b0;
        return;
      end
      if (garbage) b2.input_data = $urandom;
      @(posedge clk); #1;
      n++;
    end
    b2.input_data = v;
    @(posedge clk); #1;
  endtask

  task automatic send4(input sample_t v, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b4.valid_in   = 1'b1;
    b4.input_data = v;
    while (b4.ready_in !== 1'b1) begin
      if (n >= 2000) begin
        ok = 1'b0;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_outputs(input int n, input bit k4);
    int c;
    c = 0;
    while (((k4 ? got4_d.size() : got2_d.size()) < n) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b2.valid_in = 1'b0; b2.input_data = '0; b2.ready_out = 1'b0;
    b4.valid_in = 1'b0; b4.input_data = '0; b4.ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks += 8;
    if (b2.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b want 0", b2.valid_out); end
    if (b2.last_out !== 1'b0) begin errors++; $display("FAIL reset_last2 got %b want 0", b2.last_out); end
    if (b2.output_data !== 32'sd0) begin errors++; $display("FAIL reset_data2 got %0d want 0", b2.output_data); end
    if (b2.ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b want 1", b2.ready_in); end
    if (b4.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", b4.valid_out); end
    if (b4.last_out !== 1'b0) begin errors++; $display("FAIL reset_last4 got %b want 0", b4.last_out); end
    if (b4.output_data !== 32'sd0) begin errors++; $display("FAIL reset_data4 got %0d want 0", b4.output_data); end
    if (b4.ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", b4.ready_in); end
  endtask

  task automatic test_pixel_order();
    sample_t vals[$];
    bit ok;
    bit all_ok;
    clear_all();
    all_ok = 1'b1;
    b2.ready_out = 1'b1;
    for (int i = 0; i < 16; i++) vals.push_back(sample_t'(4 * (i + 1)));
    build_expected(vals, 2, 8, 8);
    foreach (vals[i]) begin send2(vals[i], 1'b0, ok); all_ok &= ok; end
    b2.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b0);
    checks++;
    if (!all_ok || got2_d.size() != exp_d.size()) begin
      errors++; $display("FAIL pixel_order_count got %0d want %0d", got2_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL pixel_order[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_rounding();
    sample_t vals[$];
    sample_t want[4];
    bit ok;
    bit all_ok;
    clear_all();
    all_ok = 1'b1;
    b2.ready_out = 1'b1;
    vals = '{32'sd10, -32'sd10, 32'sd7, 32'sh7FFFFFFF};
    want = '{32'sd3, -32'sd2, 32'sd2, 32'sh20000000};
    for (int i = 4; i < 16; i++) vals.push_back($urandom);
    build_expected(vals, 2, 8, 8);
    foreach (vals[i]) begin send2(vals[i], 1'b0, ok); all_ok &= ok; end
    b2.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b0);
    checks++;
    if (!all_ok || got2_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rounding_count got %0d want %0d", got2_d.size(), exp_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (got2_d[2 * i] !== want[i]) begin
        errors++; $display("FAIL rounding_const[%0d] got %0d want %0d", i, got2_d[2 * i], want[i]);
      end
      if (got2_d[2 * i + 1] !== want[i]) begin
        errors++; $display("FAIL rounding_repl[%0d] got %0d want %0d", i, got2_d[2 * i + 1], want[i]);
      end
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rounding[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_rounding_k4();
    sample_t vals[$];
    bit ok;
    bit all_ok;
    clear_all();
    all_ok = 1'b1;
    b4.ready_out = 1'b1;
    vals = '{32'sd24, -32'sd8, -32'sd9, 32'sd0};
    vals[3] = $urandom;
    build_expected(vals, 4, 8, 8);
    foreach (vals[i]) begin send4(vals[i], ok); all_ok &= ok; end
    b4.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b1);
    checks += 2;
    if (!all_ok || got4_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rounding_k4_count got %0d want %0d", got4_d.size(), exp_d.size());
    end
    if (got4_d[0] !== 32'sd2) begin
      errors++; $display("FAIL rounding_k4_const got %0d want 2", got4_d[0]);
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got4_d[i] !== exp_d[i] || got4_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rounding_k4[%0d] got %0d/%b want %0d/%b", i, got4_d[i], got4_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sample_t vals[$];
    bit ok;
    bit stalled;
    sample_t pd;
    bit pl;
    int stalls;
    clear_all();
    for (int i = 0; i < 16; i++) vals.push_back($urandom);
    build_expected(vals, 2, 8, 8);
    b2.ready_out = 1'b1;
    stalled = 1'b0;
    stalls  = 0;
    ok = 1'b1;
    fork
      begin
        bit s_ok;
        foreach (vals[i]) begin send2(vals[i], 1'b0, s_ok); ok &= s_ok; end
        b2.valid_in = 1'b0;
      end
      begin
        int c;
        c = 0;
        while (got2_d.size() < exp_d.size() && c < 4000) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            stalls++;
            if (b2.valid_out !== 1'b1 || b2.output_data !== pd || b2.last_out !== pl) begin
              errors++;
              $display("FAIL stall_hold got %b/%0d/%b want 1/%0d/%b", b2.valid_out, b2.output_data, b2.last_out, pd, pl);
            end
          end
          stalled = b2.valid_out && !b2.ready_out;
          pd = b2.output_data;
          pl = b2.last_out;
          @(posedge clk); #1;
          b2.ready_out = ~b2.ready_out;
          c++;
        end
        b2.ready_out = 1'b1;
      end
    join
    wait_outputs(exp_d.size(), 1'b0);
    checks += 2;
    if (stalls == 0) begin errors++; $display("FAIL stall_seen got 0 stalls want >0"); end
    if (!ok || got2_d.size() != exp_d.size()) begin
      errors++; $display("FAIL backpressure_count got %0d want %0d", got2_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL backpressure[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_input_blocking();
    sample_t vals[$];
    bit ok;
    bit all_ok;
    clear_all();
    all_ok = 1'b1;
    b2.ready_out = 1'b1;
    for (int i = 0; i < 16; i++) vals.push_back($urandom);
    build_expected(vals, 2, 8, 8);
    foreach (vals[i]) begin
      send2(vals[i], 1'b1, ok);
      all_ok &= ok;
      if (i == 3) begin
        checks++;
        if (b2.ready_in !== 1'b0) begin
          errors++; $display("FAIL blocking_ready got %b want 0", b2.ready_in);
        end
        b2.input_data = $urandom;
      end
    end
    b2.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b0);
    checks++;
    if (!all_ok || got2_d.size() != exp_d.size()) begin
      errors++; $display("FAIL blocking_count got %0d want %0d", got2_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL blocking[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    sample_t vals[$];
    bit ok;
    bit all_ok;
    int c;
    clear_all();
    all_ok = 1'b1;
    b2.ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin send2($urandom, 1'b0, ok); all_ok &= ok; end
    b2.valid_in = 1'b0;
    c = 0;
    while (got2_d.size() < 3 && c < 200) begin @(posedge clk); #1; c++; end
    checks++;
    if (!all_ok || got2_d.size() != 3) begin
      errors++; $display("FAIL mid_reset_pre got %0d outputs want 3", got2_d.size());
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks += 3;
    if (b2.valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", b2.valid_out); end
    if (b2.last_out !== 1'b0) begin errors++; $display("FAIL mid_reset_last got %b want 0", b2.last_out); end
    if (b2.ready_in !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", b2.ready_in); end
    clear_all();
    for (int i = 0; i < 16; i++) vals.push_back($urandom);
    build_expected(vals, 2, 8, 8);
    foreach (vals[i]) begin send2(vals[i], 1'b0, ok); all_ok &= ok; end
    b2.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b0);
    checks++;
    if (!all_ok || got2_d.size() != exp_d.size()) begin
      errors++; $display("FAIL mid_reset_count got %0d want %0d", got2_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL mid_reset[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sample_t vals[$];
    bit ok;
    bit all_ok;
    int gap;
    int want_gap;
    clear_all();
    all_ok = 1'b1;
    b2.ready_out = 1'b1;
    for (int i = 0; i < 32; i++) vals.push_back($urandom);
    build_expected(vals, 2, 8, 8);
    foreach (vals[i]) begin send2(vals[i], 1'b0, ok); all_ok &= ok; end
    b2.valid_in = 1'b0;
    wait_outputs(exp_d.size(), 1'b0);
    checks++;
    if (!all_ok || got2_d.size() != 128) begin
      errors++; $display("FAIL b2b_count got %0d want 128", got2_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got2_d[i] !== exp_d[i] || got2_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got %0d/%b want %0d/%b", i, got2_d[i], got2_l[i], exp_d[i], exp_l[i]);
      end
    end
    // Rows of 16 stream on consecutive cycles; each refill of 4 samples costs 4 idle cycles.
    for (int i = 1; i < got2_t.size(); i++) begin
      gap      = got2_t[i] - got2_t[i - 1];
      want_gap = (i % 16 == 0) ? 5 : 1;
      checks++;
      if (gap != want_gap) begin
        errors++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i, gap, want_gap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_order();
    test_rounding();
    test_rounding_k4();
    test_backpressure();
    test_input_blocking();
    test_reset_mid_emit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_pool_2d_backward.md
Name: avg_pool_2d_backward

Overview:
- Backward/unpooling counterpart of the 2D average-pooling stage for non-overlapping KxK windows (stride = K).
- Accepts a pooled gradient stream in raster order.
- Divides each value by K*K and broadcasts it to every position of its KxK window.
- Emits a full-resolution raster stream with valid/ready handshakes on both sides. Sits between the pooled-gradient source and the next layer's backward stage.

Parameters:
- DATA_W, 32, signed two's-complement sample width.
- K, 2, window size and stride; power of two, 2 or 4.
- OUT_W, 8, full-resolution frame width; multiple of K.
- OUT_H, 8, full-resolution frame height; multiple of K.
- Derived: PW = OUT_W/K, PH = OUT_H/K, S = 2*log2(K).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- valid_in  input  1  pooled sample valid
- ready_in  output  1  block can accept a pooled sample
- input_data  input  DATA_W  pooled gradient sample, signed
- valid_out  output  1  output sample valid
- ready_out  input  1  downstream accepts output
- output_data  output  DATA_W  full-resolution gradient sample, signed
- last_out  output  1  qualifies the final sample of a frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state = FILL, all counters = 0, valid_out = 0, output_data = 0, last_out = 0, ready_in = 1 from the first cycle after reset. Row buffer contents are don't-care.
- Scaling: scaled = (x + 2^(S-1)) >>> S.
  - Computed at DATA_W+1 bits with sign extension, then truncated to DATA_W. The result always fits.
  - Rounding is round-half-up toward +inf.
  - Scaling happens on accept; the row buffer stores scaled values.
- Row buffer: PW x DATA_W register array, combinational read.
- State FILL:
  - ready_in = 1.
  - Each valid_in && ready_in writes scaled input to buf[col_in] and increments col_in.
  - On the accept with col_in == PW-1: col_in <= 0, state <= EMIT.
- State EMIT:
  - ready_in = 0. valid_in and input_data are ignored.
  - Counters: rep_row in 0..K-1 and out_col in 0..OUT_W-1.
  - The output register loads when (!valid_out || ready_out). On load: output_data <= buf[out_col / K], valid_out <= 1, then out_col advances.
  - When out_col wraps, rep_row advances.
  - last_out <= 1 on the load where pooled row == PH-1, rep_row == K-1 and out_col == OUT_W-1.
  - On the load with rep_row == K-1 and out_col == OUT_W-1: state <= FILL and the pooled-row counter increments, wrapping to 0 after PH-1.
- Output register in any state:
  - If valid_out && ready_out and no new load occurs, valid_out <= 0 and last_out <= 0.
  - output_data and last_out are held stable while valid_out && !ready_out.
- Latency and throughput:
  - The last pooled sample of a row is accepted at edge E. The first output is visible after E+1.
  - With ready_out held 1, the block emits K*OUT_W samples on consecutive cycles.
  - ready_in returns 1 in the cycle after the final EMIT load. Filling the next row overlaps the drain of the last output.
- Boundary conditions:
  - Partial row when input stops: the block waits indefinitely in FILL, with no timeout.
  - Frame wrap: the pooled-row counter returns to 0 with no gap cycle. Consecutive frames run back-to-back.
  - Reset mid-operation: immediate return to the reset values. Any partial row or frame is discarded and the next accepted sample is row 0, column 0.
  - ready_out low throughout EMIT: the block holds its state with no loss and no duplication.

Decomposition:
- Package avg_pool_pkg holds:
  - the state enum (FILL, EMIT)
  - the DATA_W default
  - the function round_shift(x, S) implementing the scaling rule, shared with the forward pooling block
  - log2 helper constants for K
- One natural sub-module: avg_pool_row_buffer. It holds the PW-entry register array with one write port and one combinational read port.
- Counters, FSM and output register stay in the top module.

Test Plan:
- Pixel order: K=2, OUT_W=4, OUT_H=4, ready_out=1. Pooled inputs 4, 8, 12, 16 -> output rows [1,1,2,2], [1,1,2,2], [3,3,4,4], [3,3,4,4]. last_out is high only on the 16th output.
- Rounding: K=2, inputs 10, -10, 7, 0x7FFFFFFF -> scaled values 3, -2, 2, 0x20000000, each replicated per window. Repeat with K=4 and input 24 -> 2.
- Output backpressure: ready_out toggles 1,0,1,0 during EMIT -> output_data and last_out stay stable while stalled. Exactly K*OUT_W samples per row, with no duplicates or drops, checked against the scoreboard.
- Input blocking: valid_in held 1 with changing input_data during EMIT -> no accepts (ready_in = 0). The next row's buffer holds only values presented after ready_in returns to 1.
- Reset mid-EMIT: assert rst_n=0 for 1 cycle after the 3rd output -> next cycle valid_out=0, last_out=0, ready_in=1. A fresh frame then produces the correct full frame starting at row 0.
- Back-to-back frames: two 8x8 frames (K=2, defaults) streamed with valid_in always 1 and ready_out always 1 -> 128 outputs, last_out exactly on outputs 64 and 128, no idle cycle at the frame boundary beyond the FILL phase.
